// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and types for the configuration register file
package reg_file_pkg;

    // Default geometry of the register file
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = 4;

    // Indices of the directly exported configuration registers
    localparam int REG_ALU_A    = 0;
    localparam int REG_ALU_B    = 1;
    localparam int REG_UART_CFG = 2;
    localparam int REG_DIV      = 3;

    // UART cfg: parity enabled, even parity, prescale 32
    localparam logic [7:0] DEF_REG2_RST = 8'h81;
    // Clock divider ratio 32
    localparam logic [7:0] DEF_REG3_RST = 8'h20;

    // Outcome of the access presented in the current cycle
    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_WRITE,
        ACC_READ,
        ACC_ERR
    } accKind_t;

endpackage

// File: rtl/reg_file_cfg.sv
// rtl/reg_file_cfg.sv - parametrised single-port register file with registered read and access-error strobe
module reg_file_cfg
    import reg_file_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               DEPTH    = DEF_DEPTH,
    parameter int               ADDR_W   = DEF_ADDR_W,
    parameter logic [WIDTH-1:0] REG2_RST = DEF_REG2_RST,
    parameter logic [WIDTH-1:0] REG3_RST = DEF_REG3_RST
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] Address,
    input  logic              WrEn,
    input  logic              RdEn,
    input  logic [WIDTH-1:0]  WrData,
    output logic [WIDTH-1:0]  RdData,
    output logic              RdData_Valid,
    output logic              Acc_Err,
    output logic [WIDTH-1:0]  REG0,
    output logic [WIDTH-1:0]  REG1,
    output logic [WIDTH-1:0]  REG2,
    output logic [WIDTH-1:0]  REG3
);

    // The four configuration registers must exist and every entry must be addressable
    generate
        if (DEPTH < 4 || DEPTH > (2 ** ADDR_W)) begin : gBadDepth
            $error("reg_file_cfg: DEPTH must be in 4..2**ADDR_W");
        end
    endgenerate

    // One extra bit so that DEPTH == 2**ADDR_W is representable
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             addrOk;
    accKind_t         accKind;

    assign addrOk = ({1'b0, Address} < DEPTH_LIM);

    // Classify the request: simultaneous enables or out-of-range address are rejected
    always_comb begin
        accKind = ACC_IDLE;
        if (WrEn && RdEn) begin
            accKind = ACC_ERR;
        end else if (WrEn || RdEn) begin
            if (!addrOk) begin
                accKind = ACC_ERR;
            end else if (WrEn) begin
                accKind = ACC_WRITE;
            end else begin
                accKind = ACC_READ;
            end
        end
    end

    // Storage array; UART cfg and divider come out of reset with usable defaults
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == REG_UART_CFG) begin
                    mem[i] <= REG2_RST;
                end else if (i == REG_DIV) begin
                    mem[i] <= REG3_RST;
                end else begin
                    mem[i] <= '0;
                end
            end
        end else if (accKind == ACC_WRITE) begin
            mem[Address] <= WrData;
        end
    end

    // Registered read data plus single-cycle valid and error strobes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RdData       <= '0;
            RdData_Valid <= 1'b0;
            Acc_Err      <= 1'b0;
        end else begin
            RdData_Valid <= (accKind == ACC_READ);
            Acc_Err      <= (accKind == ACC_ERR);
            if (accKind == ACC_READ) begin
                RdData <= mem[Address];
            end
        end
    end

    assign REG0 = mem[REG_ALU_A];
    assign REG1 = mem[REG_ALU_B];
    assign REG2 = mem[REG_UART_CFG];
    assign REG3 = mem[REG_DIV];

endmodule

// File: tb/tb_reg_file_cfg.sv
// tb/tb_reg_file_cfg.sv - directed table-driven bench for reg_file_cfg
`timescale 1ns/100ps
module tb_reg_file_cfg;

    logic       clk;
    logic       rst;

    // Default 16-entry instance
    logic [3:0] address;
    logic       wrEn;
    logic       rdEn;
    logic [7:0] wrData;
    logic [7:0] rdData;
    logic       rdValid;
    logic       accErr;
    logic [7:0] reg0, reg1, reg2, reg3;

    // 12-entry instance for out-of-range addresses
    logic [3:0] address12;
    logic       wrEn12;
    logic       rdEn12;
    logic [7:0] wrData12;
    logic [7:0] rdData12;
    logic       rdValid12;
    logic       accErr12;
    logic [7:0] reg0d12, reg1d12, reg2d12, reg3d12;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] expRd;
        logic       expValid;
        logic       expErr;
    } vec_t;

    vec_t vecs[$];

    reg_file_cfg dut (
        .CLK(clk), .RST(rst), .Address(address), .WrEn(wrEn), .RdEn(rdEn),
        .WrData(wrData), .RdData(rdData), .RdData_Valid(rdValid), .Acc_Err(accErr),
        .REG0(reg0), .REG1(reg1), .REG2(reg2), .REG3(reg3)
    );

    reg_file_cfg #(.DEPTH(12)) dut12 (
        .CLK(clk), .RST(rst), .Address(address12), .WrEn(wrEn12), .RdEn(rdEn12),
        .WrData(wrData12), .RdData(rdData12), .RdData_Valid(rdValid12), .Acc_Err(accErr12),
        .REG0(reg0d12), .REG1(reg1d12), .REG2(reg2d12), .REG3(reg3d12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleAll();
        wrEn = 0; rdEn = 0; address = 0; wrData = 0;
        wrEn12 = 0; rdEn12 = 0; address12 = 0; wrData12 = 0;
    endtask

    initial begin
        idleAll();
        rst = 1'b1;

        // Expected-value table: fill 0..15 with addr+1, read back, then corner cases
        for (int i = 0; i < 16; i++)
            vecs.push_back('{1'b1, 1'b0, 4'(i), 8'(i + 1), 8'h00, 1'b0, 1'b0});
        for (int i = 0; i < 16; i++)
            vecs.push_back('{1'b0, 1'b1, 4'(i), 8'h00, 8'(i + 1), 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4'd5, 8'hFF, 8'h10, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 8'h00, 8'h10, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'd5, 8'h00, 8'h06, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 4'd7, 8'h77, 8'h06, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'd7, 8'h00, 8'h77, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd7, 8'h00, 8'h77, 1'b0, 1'b0});

        // Reset values visible before any clock edge
        #2;
        check("rst_reg0", reg0, 8'h00);
        check("rst_reg1", reg1, 8'h00);
        check("rst_reg2", reg2, 8'h81);
        check("rst_reg3", reg3, 8'h20);
        check("rst_rddata", rdData, 8'h00);
        check("rst_valid", rdValid, 1'b0);
        check("rst_err", accErr, 1'b0);
        step();
        #3 rst = 1'b0;
        step();

        foreach (vecs[k]) begin
            wrEn = vecs[k].wr; rdEn = vecs[k].rd;
            address = vecs[k].addr; wrData = vecs[k].data;
            step();
            check($sformatf("vec%0d_rddata", k), rdData, vecs[k].expRd);
            check($sformatf("vec%0d_valid", k), rdValid, vecs[k].expValid);
            check($sformatf("vec%0d_err", k), accErr, vecs[k].expErr);
        end
        idleAll();

        // Direct outputs follow writes on the same edge
        wrEn = 1; address = 0; wrData = 8'hA5;
        step();
        check("direct_reg0", reg0, 8'hA5);
        wrEn = 1; address = 1; wrData = 8'h3C;
        step();
        check("direct_reg1", reg1, 8'h3C);
        check("direct_reg0_hold", reg0, 8'hA5);
        check("direct_reg2", reg2, 8'h03);
        check("direct_reg3", reg3, 8'h04);
        idleAll();

        // Asynchronous reset pulse in mid-cycle
        #2 rst = 1'b1;
        #1;
        check("async_reg0", reg0, 8'h00);
        check("async_reg1", reg1, 8'h00);
        check("async_reg2", reg2, 8'h81);
        check("async_reg3", reg3, 8'h20);
        check("async_rddata", rdData, 8'h00);
        check("async_valid", rdValid, 1'b0);
        #1 rst = 1'b0;
        step();

        // Reset shortly after a read edge aborts the read
        wrEn = 1; address = 3; wrData = 8'h55;
        step();
        wrEn = 0; rdEn = 1; address = 3;
        @(posedge clk);
        #0.5 rst = 1'b1;
        rdEn = 0;
        #0.5;
        check("abort_rddata", rdData, 8'h00);
        check("abort_valid", rdValid, 1'b0);
        #3 rst = 1'b0;
        step();
        check("abort_post_valid", rdValid, 1'b0);
        check("abort_post_err", accErr, 1'b0);
        check("abort_post_rddata", rdData, 8'h00);
        check("abort_post_reg3", reg3, 8'h20);

        // DEPTH=12: out-of-range read and write are rejected
        rdEn12 = 1; address12 = 2;
        step();
        check("d12_rd2", rdData12, 8'h81);
        check("d12_rd2_valid", rdValid12, 1'b1);
        rdEn12 = 1; address12 = 13;
        step();
        check("d12_oor_rd_err", accErr12, 1'b1);
        check("d12_oor_rd_valid", rdValid12, 1'b0);
        check("d12_oor_rd_hold", rdData12, 8'h81);
        rdEn12 = 0; wrEn12 = 1; address12 = 14; wrData12 = 8'hAA;
        step();
        check("d12_oor_wr_err", accErr12, 1'b1);
        wrEn12 = 0;
        step();
        check("d12_err_clear", accErr12, 1'b0);
        for (int a = 0; a < 12; a++) begin
            rdEn12 = 1; address12 = 4'(a);
            step();
            check($sformatf("d12_entry%0d", a), rdData12,
                  (a == 2) ? 8'h81 : (a == 3) ? 8'h20 : 8'h00);
        end
        idleAll();
        step();
        check("d12_final_valid", rdValid12, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
